// File: rtl/dpwm_gen.sv
// Double-buffered complementary PWM with dead time (enabled by DPWM_DEADTIME_EN) and a per-period ADC trigger.
// Outputs are registered and aligned to period_start; duty changes take effect at the next period boundary, with no backpressure.
module dpwm_gen #(
  parameter int W    = 11,
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [W-1:0]    period,
  input  logic [W-1:0]    duty_in,
  input  logic            duty_valid,
  input  logic [DT_W-1:0] dt,
  output logic            pwm_hi,
  output logic            pwm_lo,
  output logic            period_start,
  output logic            sample_trig,
  output logic            duty_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef struct packed {
    logic [W-1:0]    duty;
    logic [W-1:0]    period;
    logic [DT_W-1:0] dt;
  } cfg_t;

  state_t          state, state_n;
  cfg_t            act, act_n;
  logic [W-1:0]    cnt, cnt_n;
  logic [W-1:0]    duty_sh;
  logic            pending;
  logic            load;
  logic            wrap;
  logic [DT_W-1:0] dt_eff;

  logic [W:0]      c_x, d_x, p_x, t_x;
  logic            run_n, full_n;
  logic            hi_n, lo_n, trig_n, start_n, ack_n;

`ifdef DPWM_DEADTIME_EN
  assign dt_eff = dt;
`else
  logic dt_unused;
  assign dt_unused = ^dt;
  assign dt_eff    = '0;
`endif

  // Next-state: counter, run state and the load of the active configuration.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    act_n   = act;
    load    = 1'b0;
    wrap    = (cnt == act.period);

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN, STOP: begin
        if (wrap) begin
          cnt_n = '0;
          if (enable) begin
            state_n = RUN;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n   = cnt + W'(1);
          state_n = enable ? RUN : STOP;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // A strobe on the load cycle bypasses the shadow register.
    if (load) begin
      act_n.duty   = duty_valid ? duty_in : duty_sh;
      act_n.period = (period < W'(2)) ? W'(2) : period;
      act_n.dt     = dt_eff;
    end
  end

  // Outputs are computed from the next-state view so the registers line up with the offset.
  always_comb begin
    c_x     = {1'b0, cnt_n};
    d_x     = {1'b0, act_n.duty};
    p_x     = {1'b0, act_n.period};
    t_x     = (W+1)'(act_n.dt);
    run_n   = (state_n != IDLE);
    full_n  = (d_x == '0) || (d_x >= p_x + (W+1)'(1));

    hi_n    = run_n && (c_x >= t_x) && (c_x < d_x);
`ifdef DPWM_DEADTIME_EN
    lo_n    = run_n && (c_x >= d_x + t_x) && (c_x <= p_x);
`else
    lo_n    = run_n && !hi_n;
`endif
    trig_n  = run_n && (full_n ? (c_x == '0) : (c_x == (d_x >> 1)));
    start_n = run_n && (c_x == '0);
    ack_n   = load && (pending || duty_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      act.duty   <= '0;
      act.period <= W'(2);
      act.dt     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      act   <= act_n;
    end
  end

  // Shadow duty: last write in a period wins; the load cycle consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh <= '0;
      pending <= 1'b0;
    end else begin
      if (duty_valid) begin
        duty_sh <= duty_in;
      end
      if (load) begin
        pending <= 1'b0;
      end else if (duty_valid) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_hi       <= 1'b0;
      pwm_lo       <= 1'b0;
      period_start <= 1'b0;
      sample_trig  <= 1'b0;
      duty_ack     <= 1'b0;
    end else begin
      pwm_hi       <= hi_n;
      pwm_lo       <= lo_n;
      period_start <= start_n;
      sample_trig  <= trig_n;
      duty_ack     <= ack_n;
    end
  end

endmodule

// File: tb/tb_dpwm_gen.sv
// Directed bench for dpwm_gen: expected per-offset outputs queued as stimulus is applied, checked each cycle.
module tb_dpwm_gen;

`ifdef DPWM_DEADTIME_EN
  localparam int DTX = 1;
`else
  localparam int DTX = 0;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic [10:0] period;
  logic [10:0] duty_in;
  logic        duty_valid;
  logic [3:0]  dt;
  logic        pwm_hi, pwm_lo, period_start, sample_trig, duty_ack;

  typedef struct packed {
    logic [7:0] phase;
    logic [7:0] off;
    logic [4:0] v;   // {period_start, pwm_hi, pwm_lo, sample_trig, duty_ack}
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  dpwm_gen #(.W(11), .DT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period       (period),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .dt           (dt),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start),
    .sample_trig  (sample_trig),
    .duty_ack     (duty_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_idle(input int ph);
    exp_t e;
    e.phase = 8'(ph);
    e.off   = 8'd255;
    e.v     = 5'b00000;
    sb.push_back(e);
  endtask

  // Queue n offsets of one period: hi in [hlo,hhi], lo in [llo,lhi], trigger at tr.
  task automatic push_period(input int ph, input int n, input int hlo, input int hhi,
                             input int llo, input int lhi, input int tr, input int ack);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.phase = 8'(ph);
      e.off   = 8'(k);
      e.v     = {(k == 0), (k >= hlo && k <= hhi), (k >= llo && k <= lhi),
                 (k == tr), (k == 0 && ack != 0)};
      sb.push_back(e);
    end
  endtask

  // Check the current cycle at the falling edge, then move just past the next rising edge.
  task automatic cyc();
    exp_t e;
    logic [4:0] obs;
    @(negedge clk);
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {period_start, pwm_hi, pwm_lo, sample_trig, duty_ack};
      total++;
      assert (obs === e.v)
      else begin
        bad++;
        $error("FAIL phase%0d off%0d: got start/hi/lo/trig/ack=%b want %b",
               e.phase, e.off, obs, e.v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write_duty(input logic [10:0] d);
    duty_in    = d;
    duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    period     = 11'd0;
    duty_in    = 11'd0;
    duty_valid = 1'b0;
    dt         = 4'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    push_idle(0);
    cyc();
    rst = 1'b0;
    push_idle(0);
    push_idle(0);
    cycles(2);

    // Basic duty 4, period 9, dt 0, written while idle.
    period = 11'd9;
    dt     = 4'd0;
    push_idle(1);
    write_duty(11'd4);
    enable = 1'b1;
    push_idle(1);
    cyc();
    push_period(1, 10, 0, 3, 4, 9, 2, 1);
    cycles(10);

    // Second basic period; program duty 10, period 19, dt 3 for the next.
    push_period(2, 10, 0, 3, 4, 9, 2, 0);
    period = 11'd19;
    dt     = 4'd3;
    write_duty(11'd10);
    cycles(9);

    // Dead-time period.
    push_period(3, 20, 3*DTX, 9, 10 + 3*DTX, 19, 5, 1);
    cycles(20);

    // Double buffering: 2, 6, 8 mid-period, 5 on the load cycle.
    push_period(4, 20, 3*DTX, 9, 10 + 3*DTX, 19, 5, 0);
    cycles(2);
    write_duty(11'd2);
    cycles(2);
    write_duty(11'd6);
    cyc();
    write_duty(11'd8);
    period = 11'd9;
    dt     = 4'd2;
    cycles(11);
    write_duty(11'd5);

    // Duty 5 active with single ack; queue duty 0.
    push_period(5, 10, 2*DTX, 4, 5 + 2*DTX, 9, 2, 1);
    cyc();
    write_duty(11'd0);
    cycles(8);

    // Duty 0: no hi, trigger at offset 0; queue duty 15.
    push_period(6, 10, 1, 0, 2*DTX, 9, 0, 1);
    cyc();
    write_duty(11'd15);
    cycles(8);

    // Duty 15 beyond the period: no lo, trigger at offset 0; queue duty 4.
    push_period(7, 10, 2*DTX, 9, 1, 0, 0, 1);
    cyc();
    write_duty(11'd4);
    cycles(8);

    // Enable dropped at offset 3: period completes, then idle.
    push_period(8, 10, 2*DTX, 3, 4 + 2*DTX, 9, 2, 1);
    cycles(3);
    enable = 1'b0;
    cycles(7);
    push_idle(9);
    push_idle(9);
    push_idle(9);
    cycles(3);

    // Restart, then reset at offset 2 while hi is high.
    enable = 1'b1;
    push_idle(10);
    cyc();
    push_period(10, 2, 2*DTX, 3, 4 + 2*DTX, 9, 2, 0);
    cycles(2);
    total++;
    assert (pwm_hi === 1'b1)
    else begin
      bad++;
      $error("FAIL pre_reset_hi: got %b want 1", pwm_hi);
    end
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    push_idle(10);
    push_idle(10);
    cycles(2);
    rst = 1'b0;
    push_idle(11);
    cyc();

    // Restart after reset: shadow duty cleared, no pending ack.
    enable = 1'b1;
    push_idle(11);
    cyc();
    push_period(11, 10, 1, 0, 2*DTX, 9, 0, 0);
    cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
